// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALUControl codes, as decoded by the existing ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // State-decoded (Moore) control word, held in registers
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    alu_op_t    alu_op;
  } ctrl_t;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps ALUOp/funct3/op[5]/funct7b5 to the ALU control code.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  // ALU code selection; unsupported funct3 falls back to add
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Flags funct3 values this core does not implement
  always_comb begin
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: illegal_funct = 1'b0;
      default:                        illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback.
module riscv_mc_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr
);

  state_t  state;
  state_t  state_next;
  ctrl_t   ctrl;
  alu_op_t alu_op_eff;
  logic    bad_funct;
  logic    run;
  logic    op_known;
  logic    op_ri;

  function automatic state_t next_state_f(input state_t s, input logic [6:0] o,
                                          input logic ready, input logic bad);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = bad ? S_FETCH : S_EXECR;
          OP_I:         n = bad ? S_FETCH : S_EXECI;
          OP_BEQ:       n = S_BEQ;
          OP_JAL:       n = S_JAL;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:   n = (o == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  n = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: n = ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: n = S_ALUWB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t moore_f(input state_t s, input logic [6:0] o);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.mem_read   = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_B;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = (o == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        c.adr_src  = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:  c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_op    = ALUOP_SUB;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_write  = 1'b1;
      end
      default: c.alu_op = ALUOP_ADD;
    endcase
    return c;
  endfunction

  assign state_next = next_state_f(state, op, MemReady, bad_funct);

  // State register; the Moore control word is registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ctrl  <= moore_f(S_FETCH, op);
    end else begin
      state <= state_next;
      ctrl  <= moore_f(state_next, op);
    end
  end

  assign run        = ~rst;
  assign alu_op_eff = run ? ctrl.alu_op : ALUOP_ADD;

  riscv_alu_decoder u_alu_dec (
    .alu_op        (alu_op_eff),
    .funct3        (funct3),
    .op5           (op[5]),
    .funct7b5      (funct7b5),
    .alu_control   (ALUControl),
    .illegal_funct (bad_funct)
  );

  assign op_ri    = (op == OP_R) || (op == OP_I);
  assign op_known = op_ri || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_JAL);

  // Handshake/flag-gated outputs; everything is forced idle while in reset
  assign PCWrite      = run & (ctrl.pc_write | ((state == S_FETCH) & MemReady) |
                               ((state == S_BEQ) & Zero));
  assign IRWrite      = run & (state == S_FETCH) & MemReady;
  assign IllegalInstr = run & (state == S_DECODE) & (~op_known | (op_ri & bad_funct));
  assign AdrSrc       = run & ctrl.adr_src;
  assign MemRead      = run & ctrl.mem_read;
  assign MemWrite     = run & ctrl.mem_write;
  assign RegWrite     = run & ctrl.reg_write;
  assign ResultSrc    = run ? ctrl.result_src : 2'b00;
  assign ALUSrcA      = run ? ctrl.alu_src_a : 2'b00;
  assign ALUSrcB      = run ? ctrl.alu_src_b : 2'b00;
  assign ImmSrc       = run ? ctrl.imm_src : 2'b00;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed per-cycle checks of the multicycle control unit outputs.
module tb_riscv_mc_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_mc_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .IllegalInstr(IllegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,IllegalInstr}
  logic [17:0] obs;
  assign obs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegWrite, ALUControl, IllegalInstr};

  localparam logic [17:0] E_RST     = 18'd0;
  localparam logic [17:0] E_FETCH   = {5'b10101, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_FWAIT   = {5'b00100, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_DEC     = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_DEC_ILL = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 3'b000, 1'b1};
  localparam logic [17:0] E_EXR_ADD = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_EXR_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0};
  localparam logic [17:0] E_EXI_SLT = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b101, 1'b0};
  localparam logic [17:0] E_ALUWB   = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0};
  localparam logic [17:0] E_MADR_LW = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_MADR_SW = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_MRD     = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_MWB     = {5'b00000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0};
  localparam logic [17:0] E_MWR     = {5'b01010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [17:0] E_BEQ_T   = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0};
  localparam logic [17:0] E_BEQ_N   = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0};
  localparam logic [17:0] E_JAL     = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  // Apply handshake inputs, check outputs mid-cycle, then advance one clock
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [17:0] exp);
    MemReady = mr;
    Zero     = z;
    #1;
    check_eq(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    Zero = 1'b0;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_idle", 1'b1, 1'b1, E_RST);

    // add: 4 cycles, ALU add in EXECR
    rst = 1'b0;
    cyc("add_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("add_decode", 1'b1, 1'b0, E_DEC);
    cyc("add_execr", 1'b1, 1'b0, E_EXR_ADD);
    cyc("add_aluwb", 1'b1, 1'b1, E_ALUWB);

    // sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("sub_decode", 1'b1, 1'b0, E_DEC);
    cyc("sub_execr", 1'b1, 1'b0, E_EXR_SUB);
    cyc("sub_aluwb", 1'b1, 1'b0, E_ALUWB);

    // lw with one fetch wait and three MEMREAD waits
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fetch_wait", 1'b0, 1'b0, E_FWAIT);
    cyc("lw_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("lw_decode", 1'b1, 1'b0, E_DEC);
    cyc("lw_memadr", 1'b1, 1'b0, E_MADR_LW);
    cyc("lw_memread_w1", 1'b0, 1'b0, E_MRD);
    cyc("lw_memread_w2", 1'b0, 1'b0, E_MRD);
    cyc("lw_memread_w3", 1'b0, 1'b0, E_MRD);
    cyc("lw_memread_rdy", 1'b1, 1'b0, E_MRD);
    cyc("lw_memwb", 1'b1, 1'b0, E_MWB);

    // sw with one MEMWRITE wait
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("sw_decode", 1'b1, 1'b0, E_DEC);
    cyc("sw_memadr", 1'b1, 1'b0, E_MADR_SW);
    cyc("sw_memwrite_w", 1'b0, 1'b0, E_MWR);
    cyc("sw_memwrite_rdy", 1'b1, 1'b0, E_MWR);

    // beq taken, then not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc("beqt_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("beqt_decode", 1'b1, 1'b1, E_DEC);
    cyc("beqt_beq", 1'b1, 1'b1, E_BEQ_T);
    cyc("beqn_fetch", 1'b1, 1'b1, E_FETCH);
    cyc("beqn_decode", 1'b1, 1'b0, E_DEC);
    cyc("beqn_beq", 1'b1, 1'b0, E_BEQ_N);

    // slti
    set_instr(7'b0010011, 3'b010, 1'b0);
    cyc("slti_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("slti_decode", 1'b1, 1'b0, E_DEC);
    cyc("slti_execi", 1'b1, 1'b0, E_EXI_SLT);
    cyc("slti_aluwb", 1'b1, 1'b0, E_ALUWB);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("jal_decode", 1'b1, 1'b0, E_DEC);
    cyc("jal_jal", 1'b1, 1'b0, E_JAL);
    cyc("jal_aluwb", 1'b1, 1'b0, E_ALUWB);

    // illegal opcode, then illegal funct3 on an R-type
    set_instr(7'b0000000, 3'b000, 1'b0);
    cyc("illop_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("illop_decode", 1'b1, 1'b0, E_DEC_ILL);
    set_instr(7'b0110011, 3'b001, 1'b0);
    cyc("illf3_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("illf3_decode", 1'b1, 1'b0, E_DEC_ILL);

    // reset in the middle of a MEMREAD wait
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("rlw_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("rlw_decode", 1'b1, 1'b0, E_DEC);
    cyc("rlw_memadr", 1'b1, 1'b0, E_MADR_LW);
    cyc("rlw_memread_w", 1'b0, 1'b0, E_MRD);
    rst = 1'b1;
    cyc("rlw_in_reset", 1'b0, 1'b1, E_RST);
    rst = 1'b0;
    cyc("rlw_post_fetch_wait", 1'b0, 1'b0, E_FWAIT);
    cyc("rlw_post_fetch", 1'b1, 1'b0, E_FETCH);
    cyc("rlw_post_decode", 1'b1, 1'b0, E_DEC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
